// File: rtl/axi_lite_host_cmd_queue.sv
// Command sequencer in front of an AXI-Lite master host port.
// Queues write/read commands, issues them one at a time, collects read data
// in a response FIFO and halts issue when a transaction does not complete in time.
module axi_lite_host_cmd_queue #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int CMD_DEPTH = 4,
    parameter int RSP_DEPTH = 4,
    parameter int TIMEOUT   = 1024
) (
    input  logic                         ACLK,
    input  logic                         ARESET,
    // command push side
    input  logic                         cmd_valid,
    output logic                         cmd_ready,
    input  logic                         cmd_write,
    input  logic [ADDR_W-1:0]            cmd_addr,
    input  logic [DATA_W-1:0]            cmd_wdata,
    // read response side
    output logic                         rsp_valid,
    input  logic                         rsp_ready,
    output logic [DATA_W-1:0]            rsp_data,
    output logic                         rsp_err,
    // master host interface
    output logic                         transfer,
    input  logic                         ready,
    output logic [ADDR_W-1:0]            addr,
    output logic [DATA_W-1:0]            wdata,
    output logic                         write,
    input  logic [DATA_W-1:0]            rdata,
    // status
    output logic                         busy,
    output logic                         timeout_err,
    input  logic                         err_clr,
    output logic [$clog2(CMD_DEPTH):0]   cmd_level
);

    localparam int CPW = $clog2(CMD_DEPTH);
    localparam int CCW = CPW + 1;
    localparam int RPW = $clog2(RSP_DEPTH);
    localparam int RCW = RPW + 1;
    localparam int TW  = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    localparam logic [CCW-1:0] CMD_FULL_LVL = CCW'(CMD_DEPTH);
    localparam logic [RCW-1:0] RSP_FULL_LVL = RCW'(RSP_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_HALT
    } state_t;

    state_t state, state_nxt;

    // command FIFO storage and bookkeeping
    logic [ADDR_W-1:0] cmd_addr_mem [CMD_DEPTH];
    logic [DATA_W-1:0] cmd_data_mem [CMD_DEPTH];
    logic              cmd_wr_mem   [CMD_DEPTH];
    logic [CPW-1:0]    cmd_wp, cmd_rp;
    logic [CCW-1:0]    cmd_cnt;
    logic              cmd_push, cmd_pop;

    // response FIFO storage and bookkeeping
    logic [DATA_W-1:0] rsp_data_mem [RSP_DEPTH];
    logic              rsp_err_mem  [RSP_DEPTH];
    logic [RPW-1:0]    rsp_wp, rsp_rp;
    logic [RCW-1:0]    rsp_cnt;
    logic              rsp_push, rsp_pop;
    logic              rsp_push_err;
    logic [DATA_W-1:0] rsp_push_data;

    logic [TW-1:0]     timer;
    logic              timeout_hit;
    logic              head_ok;

    // Ready comes from the registered count only, so a pop cannot make room
    // for a push in the same cycle.
    assign cmd_ready = (cmd_cnt != CMD_FULL_LVL);
    assign cmd_push  = cmd_valid && cmd_ready;
    assign cmd_level = cmd_cnt;

    assign rsp_valid = (rsp_cnt != '0);
    assign rsp_pop   = rsp_valid && rsp_ready;
    // Storage is not reset, so the head is masked while the FIFO is empty.
    assign rsp_data  = rsp_valid ? rsp_data_mem[rsp_rp] : '0;
    assign rsp_err   = rsp_valid ? rsp_err_mem[rsp_rp]  : 1'b0;

    assign busy = (state != S_IDLE) || (cmd_cnt != '0);

    // A read may only issue when its response has a guaranteed slot.
    assign head_ok     = (cmd_cnt != '0) && (cmd_wr_mem[cmd_rp] || (rsp_cnt != RSP_FULL_LVL));
    assign timeout_hit = (TIMEOUT != 0) && (timer == TW'(TIMEOUT));

    // Command FIFO payload write
    // NOTE: FIFO storage has no reset; validity is tracked by the count, and
    // leaving data arrays unreset lets them map onto plain RAM/register files.
    always_ff @(posedge ACLK) begin
        if (cmd_push) begin
            cmd_addr_mem[cmd_wp] <= cmd_addr;
            cmd_data_mem[cmd_wp] <= cmd_wdata;
            cmd_wr_mem[cmd_wp]   <= cmd_write;
        end
    end

    // Command FIFO pointers and occupancy
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            cmd_wp  <= '0;
            cmd_rp  <= '0;
            cmd_cnt <= '0;
        end else begin
            if (cmd_push) cmd_wp <= cmd_wp + CPW'(1);
            if (cmd_pop)  cmd_rp <= cmd_rp + CPW'(1);
            case ({cmd_push, cmd_pop})
                2'b10:   cmd_cnt <= cmd_cnt + CCW'(1);
                2'b01:   cmd_cnt <= cmd_cnt - CCW'(1);
                default: cmd_cnt <= cmd_cnt;
            endcase
        end
    end

    // Response FIFO payload write
    always_ff @(posedge ACLK) begin
        if (rsp_push) begin
            rsp_data_mem[rsp_wp] <= rsp_push_data;
            rsp_err_mem[rsp_wp]  <= rsp_push_err;
        end
    end

    // Response FIFO pointers and occupancy
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            rsp_wp  <= '0;
            rsp_rp  <= '0;
            rsp_cnt <= '0;
        end else begin
            if (rsp_push) rsp_wp <= rsp_wp + RPW'(1);
            if (rsp_pop)  rsp_rp <= rsp_rp + RPW'(1);
            case ({rsp_push, rsp_pop})
                2'b10:   rsp_cnt <= rsp_cnt + RCW'(1);
                2'b01:   rsp_cnt <= rsp_cnt - RCW'(1);
                default: rsp_cnt <= rsp_cnt;
            endcase
        end
    end

    // FSM state, WAIT timer, sticky error and held master request fields
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state       <= S_IDLE;
            timer       <= '0;
            timeout_err <= 1'b0;
            addr        <= '0;
            wdata       <= '0;
            write       <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == S_ISSUE) begin
                timer <= TW'(1);
            end else if (state == S_WAIT) begin
                timer <= timer + TW'(1);
            end
            if (state == S_WAIT && state_nxt == S_HALT) begin
                timeout_err <= 1'b1;
            end else if (state == S_HALT && err_clr) begin
                timeout_err <= 1'b0;
            end
            if (cmd_pop) begin
                addr  <= cmd_addr_mem[cmd_rp];
                wdata <= cmd_data_mem[cmd_rp];
                write <= cmd_wr_mem[cmd_rp];
            end
        end
    end

    // Next-state, issue pop, start pulse and response push
    // NOTE: every signal gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    always_comb begin
        state_nxt     = state;
        cmd_pop       = 1'b0;
        transfer      = 1'b0;
        rsp_push      = 1'b0;
        rsp_push_err  = 1'b0;
        rsp_push_data = '0;
        case (state)
            S_IDLE: begin
                if (head_ok) begin
                    cmd_pop   = 1'b1;
                    state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                transfer  = 1'b1;
                state_nxt = S_WAIT;
            end
            S_WAIT: begin
                // Completion in the final allowed cycle beats the timeout.
                if (ready) begin
                    state_nxt = S_IDLE;
                    if (!write) begin
                        rsp_push      = 1'b1;
                        rsp_push_data = rdata;
                    end
                end else if (timeout_hit) begin
                    state_nxt = S_HALT;
                    if (!write) begin
                        rsp_push     = 1'b1;
                        rsp_push_err = 1'b1;
                    end
                end
            end
            S_HALT: begin
                if (err_clr) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

endmodule
